// File: rtl/spm_pkg.sv
// Shared definitions for the signed-multiplier requester: FSM state
// encoding and the default operand width / watchdog limit.
package spm_pkg;

  localparam int SPM_DEFAULT_WIDTH   = 32;
  localparam int SPM_DEFAULT_TIMEOUT = 80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } spm_state_e;

endpackage

// File: rtl/spm_wdog.sv
// Watchdog for the BUSY phase of spm_requester.
// Counts enabled cycles since the last clear. 'expired' is high during the
// TIMEOUT-th enabled cycle, which is the cycle the counter value reaches
// TIMEOUT once that cycle is included.
module spm_wdog import spm_pkg::*; #(
  parameter int TIMEOUT = SPM_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/spm_requester.sv
// spm_requester: valid/ready front end for a start/done signed multiplier.
// Accepts an operand pair, holds spm_start high until the multiplier reports
// done, presents the product until it is consumed, then waits for done to
// drop before accepting the next pair.
// Optional feature: define SPM_TIMEOUT_EN to abort a BUSY phase that lasts
// TIMEOUT cycles; the aborted result is rsp_prod=0 with rsp_err=1.
//
// state | meaning
// IDLE  | ready for a new operand pair (req_ready=1)
// BUSY  | spm_start high, waiting for spm_done (or watchdog)
// RESP  | rsp_valid high, holding result until rsp_ready
// DRAIN | spm_start low, waiting for the multiplier to drop spm_done
module spm_requester import spm_pkg::*; #(
  parameter int WIDTH   = SPM_DEFAULT_WIDTH,
  parameter int TIMEOUT = SPM_DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_mc,
  input  logic [WIDTH-1:0]   req_mp,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_prod,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   spm_mc,
  output logic [WIDTH-1:0]   spm_mp,
  output logic               spm_start,
  input  logic [2*WIDTH-1:0] spm_prod,
  input  logic               spm_done
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("spm_requester: TIMEOUT must be at least 1");
  end

  spm_state_e         state_q, state_d;
  logic [WIDTH-1:0]   spm_mc_q, spm_mc_d;
  logic [WIDTH-1:0]   spm_mp_q, spm_mp_d;
  logic [2*WIDTH-1:0] rsp_prod_q, rsp_prod_d;

`ifdef SPM_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic wd_clr, wd_expired;

  spm_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (state_q == BUSY),
    .expired (wd_expired)
  );
`endif

  // Next state and datapath loads; everything holds unless a transition fires.
  always_comb begin
    state_d    = state_q;
    spm_mc_d   = spm_mc_q;
    spm_mp_d   = spm_mp_q;
    rsp_prod_d = rsp_prod_q;
`ifdef SPM_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
    wd_clr     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          spm_mc_d = req_mc;
          spm_mp_d = req_mp;
          state_d  = BUSY;
`ifdef SPM_TIMEOUT_EN
          wd_clr   = 1'b1;
`endif
        end
      end
      BUSY: begin
        // A real done in the same cycle as expiry still delivers the product.
        if (spm_done) begin
          rsp_prod_d = spm_prod;
          state_d    = RESP;
`ifdef SPM_TIMEOUT_EN
          rsp_err_d  = 1'b0;
        end else if (wd_expired) begin
          rsp_prod_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The multiplier may still show done from the finished operation.
        if (!spm_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      spm_mc_q   <= '0;
      spm_mp_q   <= '0;
      rsp_prod_q <= '0;
    end else begin
      state_q    <= state_d;
      spm_mc_q   <= spm_mc_d;
      spm_mp_q   <= spm_mp_d;
      rsp_prod_q <= rsp_prod_d;
    end
  end

`ifdef SPM_TIMEOUT_EN
  // Error flag travels with the product it qualifies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Handshake and start are decoded from the state register so that an
  // asynchronous reset drops spm_start immediately.
  assign req_ready = (state_q == IDLE);
  assign spm_start = (state_q == BUSY);
  assign rsp_valid = (state_q == RESP);
  assign rsp_prod  = rsp_prod_q;
  assign spm_mc    = spm_mc_q;
  assign spm_mp    = spm_mp_q;

endmodule

// File: tb/tb_spm_requester.sv
// Self-checking bench for spm_requester with an attached behavioural
// multiplier whose start-to-done latency is programmable.
module tb_spm_requester;

  localparam int W  = 32;
  localparam int TO = 30;
`ifdef SPM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [W-1:0]   req_mc = '0;
  logic [W-1:0]   req_mp = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [2*W-1:0] rsp_prod;
  logic           rsp_err;
  logic [W-1:0]   spm_mc, spm_mp;
  logic           spm_start;
  logic [2*W-1:0] spm_prod;
  logic           spm_done;

  spm_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mc    (req_mc),
    .req_mp    (req_mp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_prod  (rsp_prod),
    .rsp_err   (rsp_err),
    .spm_mc    (spm_mc),
    .spm_mp    (spm_mp),
    .spm_start (spm_start),
    .spm_prod  (spm_prod),
    .spm_done  (spm_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- multiplier stub ----------------
  // done rises in the stub_n-th cycle of start and stays high for two
  // cycles after start falls, so DRAIN has something to wait out.
  int          stub_n   = 3;
  bit          stub_off = 1'b0;
  int          st_cnt, st_n;
  logic        st_h1, st_h2;
  logic        done_now;
  logic [63:0] junk;

  assign done_now = spm_start && !stub_off && (st_cnt >= st_n - 1);
  assign spm_done = done_now | st_h1 | st_h2;
  assign spm_prod = spm_done ? 64'(longint'($signed(spm_mc)) * longint'($signed(spm_mp))) : junk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt <= 0;
      st_n   <= 1;
      st_h1  <= 1'b0;
      st_h2  <= 1'b0;
      junk   <= 64'hDEAD_BEEF_0BAD_F00D;
    end else begin
      st_h1 <= done_now;
      st_h2 <= st_h1;
      junk  <= {$urandom, $urandom};
      if (!spm_start) begin
        st_cnt <= 0;
        st_n   <= stub_n;
      end else begin
        st_cnt <= st_cnt + 1;
      end
    end
  end

  // ---------------- reference model + compare ----------------
  typedef struct {
    logic [63:0] prod;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [63:0] log_prod[$];
  logic        log_err[$];

  bit          lat_chk = 1'b1;
  bit          b2b_chk = 1'b0;
  bit          acc_last = 1'b0;
  bit          inflight = 1'b0;
  bit          have_acc = 1'b0;
  bit          prev_v = 1'b0, prev_rdy = 1'b0, prev_start = 1'b0, prev_err = 1'b0;
  bit          op_off = 1'b0;
  logic [63:0] prev_prod = '0;
  logic [W-1:0] exp_mc = '0, exp_mp = '0;
  int          acc_cyc = 0, start_cyc = 0, op_n = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      inflight = 1'b0; have_acc = 1'b0; acc_last = 1'b0;
      prev_v = 1'b0; prev_rdy = 1'b0; prev_start = 1'b0;
      exp_mc = '0; exp_mp = '0;
    end else begin
      check({spm_mc, spm_mp} == {exp_mc, exp_mp}, "operands", {spm_mc, spm_mp}, {exp_mc, exp_mp});
      check(spm_start == inflight, "spm_start", spm_start, inflight);
      if (req_ready)
        check(!spm_start && !rsp_valid && q.size() == 0, "ready_only_idle",
              {spm_start, rsp_valid}, 0);
      if (spm_start)
        check(!rsp_valid, "start_vs_valid", rsp_valid, 0);

      if (spm_start && !prev_start) begin
        start_cyc = cyc;
        op_n      = st_n;
        op_off    = stub_off;
      end

      if (rsp_valid) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_rsp", 1, 0);
        end else begin
          check(rsp_prod == q[0].prod, "rsp_prod", rsp_prod, q[0].prod);
          check(rsp_err == q[0].err, "rsp_err", rsp_err, q[0].err);
        end
        if (prev_v && !prev_rdy)
          check(rsp_prod == prev_prod && rsp_err == prev_err, "rsp_stable", rsp_prod, prev_prod);
        if (!prev_v && lat_chk)
          check(cyc - acc_cyc == (op_off ? TO : op_n) + 1, "latency",
                cyc - acc_cyc, (op_off ? TO : op_n) + 1);
        if (rsp_ready) begin
          log_prod.push_back(rsp_prod);
          log_err.push_back(rsp_err);
          if (q.size() != 0) void'(q.pop_front());
        end
      end

      if (spm_start && (spm_done || (TO_EN && stub_off && (cyc - start_cyc + 1 >= TO))))
        inflight = 1'b0;

      if (req_valid && req_ready) begin
        exp_t e;
        if (TO_EN && stub_off) begin
          e.prod = '0;
          e.err  = 1'b1;
        end else begin
          e.prod = 64'(longint'($signed(req_mc)) * longint'($signed(req_mp)));
          e.err  = 1'b0;
        end
        q.push_back(e);
        inflight = 1'b1;
        exp_mc   = req_mc;
        exp_mp   = req_mp;
        if (b2b_chk && have_acc)
          check(cyc - acc_cyc == stub_n + 4, "throughput", cyc - acc_cyc, stub_n + 4);
        acc_cyc  = cyc;
        have_acc = 1'b1;
      end

      acc_last   = req_valid && req_ready;
      prev_v     = rsp_valid;
      prev_rdy   = rsp_ready;
      prev_prod  = rsp_prod;
      prev_err   = rsp_err;
      prev_start = spm_start;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [W-1:0] mc, input logic [W-1:0] mp);
    int guard = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_mc    = mc;
    req_mp    = mp;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      guard++;
      if (guard > 2000) begin
        check(1'b0, "accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_mc    = $urandom;
    req_mp    = $urandom;
  endtask

  task automatic wait_idle(input int max_cyc);
    int guard = 0;
    while (1) begin
      @(negedge clk);
      if (q.size() == 0 && !inflight && req_ready) break;
      guard++;
      if (guard > max_cyc) begin
        check(1'b0, "idle_timeout", q.size(), 0);
        break;
      end
    end
  endtask

  function automatic longint last_prod(input int back);
    if (log_prod.size() <= back) return 64'h7FFF_FFFF_FFFF_FFFF;
    return longint'(log_prod[log_prod.size() - 1 - back]);
  endfunction

  function automatic logic last_err();
    if (log_err.size() == 0) return 1'bx;
    return log_err[log_err.size() - 1];
  endfunction

  initial begin
    #(1_000_000);
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    #2;
    check(req_ready == 1'b1, "rst_req_ready", req_ready, 1);
    check(spm_start == 1'b0, "rst_spm_start", spm_start, 0);
    check(rsp_valid == 1'b0, "rst_rsp_valid", rsp_valid, 0);
    check(rsp_err == 1'b0, "rst_rsp_err", rsp_err, 0);
    check(rsp_prod == '0, "rst_rsp_prod", rsp_prod, 0);
    check({spm_mc, spm_mp} == '0, "rst_operands", {spm_mc, spm_mp}, 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // 3 x 4
    stub_n = 3;
    send(32'd3, 32'd4);
    wait_idle(200);
    check(last_prod(0) == 12, "prod_3x4", last_prod(0), 12);
    check(last_err() == 1'b0, "err_3x4", last_err(), 0);

    // back-to-back pair, throughput N+4
    stub_n = 5;
    send(-32'sd15, 32'sd10);
    b2b_chk = 1'b1;
    send(-32'sd159, -32'sd129);
    wait_idle(200);
    b2b_chk = 1'b0;
    check(last_prod(1) == -150, "prod_m15x10", last_prod(1), -150);
    check(last_prod(0) == 20511, "prod_m159xm129", last_prod(0), 20511);

    // corner operands
    stub_n = 1;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(200);
    check(last_prod(0) == 1, "prod_m1xm1", last_prod(0), 1);
    stub_n = 7;
    send(32'h0F0F_F0FF, 32'h0F0F_F0FF);
    wait_idle(200);
    check(last_prod(0) == longint'(32'sh0F0F_F0FF) * longint'(32'sh0F0F_F0FF),
          "prod_square", last_prod(0), longint'(32'sh0F0F_F0FF) * longint'(32'sh0F0F_F0FF));

    // backpressure
    stub_n = 2;
    rsp_ready = 1'b0;
    send(32'd7, -32'sd9);
    begin
      int guard = 0;
      while (!rsp_valid && guard < 200) begin
        @(negedge clk);
        guard++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check(rsp_valid == 1'b1, "bp_valid", rsp_valid, 1);
      check(longint'(rsp_prod) == -63, "bp_prod", rsp_prod, 64'(-63));
      check(req_ready == 1'b0 && spm_start == 1'b0, "bp_idle_outputs", {req_ready, spm_start}, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_idle(200);

    // done never arrives
    stub_off = 1'b1;
    stub_n   = 2;
`ifdef SPM_TIMEOUT_EN
    send(32'd5, 32'd6);
    wait_idle(TO + 50);
    check(last_prod(0) == 0, "timeout_prod", last_prod(0), 0);
    check(last_err() == 1'b1, "timeout_err", last_err(), 1);
    stub_off = 1'b0;
`else
    lat_chk = 1'b0;
    send(32'd5, 32'd6);
    repeat (120) @(negedge clk);
    check(spm_start == 1'b1 && rsp_valid == 1'b0, "wait_forever", {spm_start, rsp_valid}, 2'b10);
    stub_off = 1'b0;
    wait_idle(200);
    check(last_prod(0) == 30, "late_done_prod", last_prod(0), 30);
    lat_chk = 1'b1;
`endif

    // reset 20 cycles into BUSY
    stub_n = 40;
    send(32'd11, 32'd13);
    repeat (19) @(posedge clk);
    #2;
    check(spm_start == 1'b1, "pre_rst_start", spm_start, 1);
    #1 rst = 1'b1;
    #1;
    check(spm_start == 1'b0, "rst_mid_start", spm_start, 0);
    check(rsp_valid == 1'b0, "rst_mid_valid", rsp_valid, 0);
    check(req_ready == 1'b1, "rst_mid_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    stub_n = 4;
    send(-32'sd2, 32'sd21);
    wait_idle(200);
    check(last_prod(0) == -42, "post_rst_prod", last_prod(0), -42);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      stub_n    = $urandom_range(1, 8);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid || acc_last) begin
        req_valid = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) begin
          req_mc = W'($signed($urandom_range(0, 63)) - 32);
          req_mp = W'($signed($urandom_range(0, 63)) - 32);
        end else begin
          req_mc = $urandom;
          req_mp = $urandom;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_requester.md
SPM_REQUESTER -- requirements
Module: spm_requester

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width; the product is 2*WIDTH.
REQ-002 SHALL have parameter TIMEOUT, default 80: number of BUSY cycles allowed before abort (used only with SPM_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1: requester offers an operand pair.
REQ-006 SHALL have port req_ready, output, 1: block accepts the pair this cycle.
REQ-007 SHALL have ports req_mc and req_mp, input, WIDTH each: signed multiplicand and multiplier.
REQ-008 SHALL have port rsp_valid, output, 1: a result is presented.
REQ-009 SHALL have port rsp_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port rsp_prod, output, 2*WIDTH: signed product.
REQ-011 SHALL have port rsp_err, output, 1: result aborted by timeout.
REQ-012 SHALL have ports spm_mc and spm_mp, output, WIDTH each: operands driven to the multiplier.
REQ-013 SHALL have port spm_start, output, 1: multiplier start, held high for the whole operation.
REQ-014 SHALL have port spm_prod, input, 2*WIDTH: multiplier product.
REQ-015 SHALL have port spm_done, input, 1: multiplier product valid.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP, DRAIN.
REQ-017 SHALL drive req_ready=1 only in IDLE.
REQ-018 IDLE: on req_valid&&req_ready SHALL register req_mc/req_mp into spm_mc/spm_mp and go to BUSY.
REQ-019 SHALL assert spm_start exactly in BUSY, starting the cycle after acceptance; spm_mc/spm_mp are already stable when it rises and SHALL stay constant until the next acceptance.
REQ-020 BUSY: on spm_done=1 SHALL register spm_prod into rsp_prod, set rsp_err=0, deassert spm_start, and go to RESP.
REQ-021 RESP: SHALL hold rsp_valid=1 with rsp_prod/rsp_err stable until rsp_valid&&rsp_ready, then go to DRAIN.
REQ-022 DRAIN: SHALL keep spm_start=0 and go to IDLE on the first cycle with spm_done=0; the minimum start-low gap is one cycle.
REQ-023 SHALL ignore req_valid and spm_done in any state where they have no defined transition.
REQ-024 Best-case latency from acceptance to rsp_valid SHALL be N+1 cycles, where N is the multiplier's start-to-done cycle count.
REQ-025 Back-to-back throughput SHALL be one operation per N+4 cycles when rsp_ready is held at 1.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE; spm_start=0; rsp_valid=0; rsp_err=0; rsp_prod=0; spm_mc=0; spm_mp=0; timeout counter=0.
REQ-027 Reset mid-operation SHALL drop spm_start in the same cycle and discard any pending result.

Configuration
REQ-028 With SPM_TIMEOUT_EN defined: a counter SHALL clear on entry to BUSY and increment each BUSY cycle. If it reaches TIMEOUT without spm_done, the block SHALL set rsp_prod=0 and rsp_err=1, deassert spm_start, and go to RESP.
REQ-029 Without SPM_TIMEOUT_EN: there SHALL be no counter, BUSY SHALL wait indefinitely, and rsp_err SHALL be tied to 0.

Structure
REQ-030 The FSM state enum, the default WIDTH and the default TIMEOUT SHALL live in shared package spm_pkg.
REQ-031 The timeout counter SHALL be sub-module spm_wdog (inputs clk, rst, clr, en; output expired), instantiated only under SPM_TIMEOUT_EN.

Verification
REQ-032 Stimulus mc=3, mp=4 with a real multiplier attached -> rsp_prod=12, rsp_err=0, and spm_start high continuously until done.
REQ-033 Stimulus mc=-15, mp=10, then mc=-159, mp=-129 back-to-back -> results -150, then 20511; spm_start low for at least one cycle between the two operations.
REQ-034 Stimulus mc=mp=32'hFFFF_FFFF -> rsp_prod=1; stimulus mc=mp=32'h0F0F_F0FF -> rsp_prod equal to the signed square of 0x0F0FF0FF.
REQ-035 Backpressure: rsp_ready held low for 10 cycles -> rsp_valid and rsp_prod stable throughout, req_ready=0, spm_start=0.
REQ-036 Timeout (SPM_TIMEOUT_EN defined, multiplier stub never asserts done) -> rsp_valid with rsp_err=1 and rsp_prod=0 exactly TIMEOUT cycles after entering BUSY.
REQ-037 rst pulsed 20 cycles into BUSY -> spm_start=0 and rsp_valid=0 immediately; the next request completes correctly.
